// File: rtl/write_data_pkg.sv
// write_data_pkg
//   Shared definitions for the BMP frame writer: FSM state encoding,
//   pixel-pair packing order and row geometry derivation.
package write_data_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Two pixels per memory word, so a row holds half as many words as pixels.
    function automatic int pairs_per_row(input int image_width);
        return image_width / 2;
    endfunction

    // BMP pixel order is B,G,R from the lowest byte; the even pixel sits low.
    function automatic logic [47:0] pack_pair(
        input logic [7:0] r0, input logic [7:0] g0, input logic [7:0] b0,
        input logic [7:0] r1, input logic [7:0] g1, input logic [7:0] b1
    );
        return {r1, g1, b1, r0, g0, b0};
    endfunction

endpackage

// File: rtl/bmp_addr_gen.sv
// bmp_addr_gen
//   Row/column counters for the pixel-pair stream and the bottom-up BMP
//   word address of the pair being accepted this cycle.
//   Ports:
//     clk, reset   - clock, asynchronous active-low reset
//     start_i      - frame start this cycle; the current pair is (0,0)
//     adv_i        - a pair is accepted this cycle
//     addr_o       - word address of the pair presented this cycle
//     last_o       - the pair presented this cycle is the frame's last
module bmp_addr_gen
    import write_data_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 768,
    parameter int IMAGE_HEIGHT = 512,
    parameter int ADDR_WIDTH   = 18
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  adv_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o
);

    localparam int PPR = pairs_per_row(IMAGE_WIDTH);
    localparam int CW  = (PPR > 1) ? $clog2(PPR) : 1;
    localparam int RW  = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

    logic [CW-1:0] col_q, col_d, col_cur;
    logic [RW-1:0] row_q, row_d, row_cur;

    always_comb begin
        // A frame start overrides the stored position so a pair in the same
        // cycle lands at (0,0).
        col_cur = start_i ? '0 : col_q;
        row_cur = start_i ? '0 : row_q;

        last_o = (int'(col_cur) == PPR - 1) && (int'(row_cur) == IMAGE_HEIGHT - 1);
        addr_o = ADDR_WIDTH'((IMAGE_HEIGHT - 1 - int'(row_cur)) * PPR + int'(col_cur));

        col_d = col_cur;
        row_d = row_cur;
        if (adv_i) begin
            if (int'(col_cur) == PPR - 1) begin
                col_d = '0;
                row_d = (int'(row_cur) == IMAGE_HEIGHT - 1) ? '0 : row_cur + 1'b1;
            end else begin
                col_d = col_cur + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/write_data.sv
// write_data
//   Reorders a two-pixels-per-clock RGB stream into bottom-up BMP layout and
//   issues one 48-bit write per pixel pair to an external frame memory.
//   Ports:
//     clk, reset                  - clock, asynchronous active-low reset
//     vertical_Pulse              - frame-active level; rising edge starts a frame
//     horizontal_Pulse            - pixel-pair valid
//     data_R0/G0/B0, data_R1/G1/B1 - even / odd pixel components
//     wr_en, wr_addr, wr_data     - registered memory write port
//     pair_count                  - pairs written in the current frame
//     write_done                  - frame complete (level)
//     overrun                     - sticky stream error, cleared only by reset
module write_data
    import write_data_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 768,
    parameter int IMAGE_HEIGHT = 512,
    parameter int ADDR_WIDTH   = 18
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vertical_Pulse,
    input  logic                  horizontal_Pulse,
    input  logic [7:0]            data_R0,
    input  logic [7:0]            data_G0,
    input  logic [7:0]            data_B0,
    input  logic [7:0]            data_R1,
    input  logic [7:0]            data_G1,
    input  logic [7:0]            data_B1,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [47:0]           wr_data,
    output logic [ADDR_WIDTH:0]   pair_count,
    output logic                  write_done,
    output logic                  overrun
);

    state_e                state_q;
    logic                  vp_prev_q;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [47:0]           wr_data_q;
    logic [ADDR_WIDTH:0]   pair_count_q;
    logic                  write_done_q;
    logic                  overrun_q;

    logic                  rise;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  last;

    always_comb begin
        rise   = vertical_Pulse & ~vp_prev_q;
        accept = horizontal_Pulse & (rise | (state_q == WRITE));
    end

    bmp_addr_gen #(
        .IMAGE_WIDTH (IMAGE_WIDTH),
        .IMAGE_HEIGHT(IMAGE_HEIGHT),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_addr_gen (
        .clk    (clk),
        .reset  (reset),
        .start_i(rise),
        .adv_i  (accept),
        .addr_o (next_addr),
        .last_o (last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            vp_prev_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            pair_count_q <= '0;
            write_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            vp_prev_q <= vertical_Pulse;
            wr_en_q   <= accept;
            if (accept) begin
                wr_addr_q <= next_addr;
                wr_data_q <= pack_pair(data_R0, data_G0, data_B0,
                                       data_R1, data_G1, data_B1);
            end

            // Dropped pair outside a frame, or a frame cut short by a new edge.
            if ((horizontal_Pulse && !accept) || (rise && state_q == WRITE))
                overrun_q <= 1'b1;

            if (rise) begin
                pair_count_q <= {{ADDR_WIDTH{1'b0}}, accept};
                write_done_q <= accept & last;
                state_q      <= (accept && last) ? DONE : WRITE;
            end else if (accept) begin
                pair_count_q <= pair_count_q + 1'b1;
                if (last) begin
                    write_done_q <= 1'b1;
                    state_q      <= DONE;
                end
            end
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign pair_count = pair_count_q;
    assign write_done = write_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_write_data.sv
module tb_write_data;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          vp = 1'b0;
    logic          hp = 1'b0;
    logic [7:0]    r0 = '0, g0 = '0, b0 = '0, r1 = '0, g1 = '0, b1 = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [47:0]   wr_data;
    logic [AW:0]   pair_count;
    logic          write_done;
    logic          overrun;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    write_data #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .vertical_Pulse  (vp),
        .horizontal_Pulse(hp),
        .data_R0         (r0),
        .data_G0         (g0),
        .data_B0         (b0),
        .data_R1         (r1),
        .data_G1         (g1),
        .data_B1         (b1),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .pair_count      (pair_count),
        .write_done      (write_done),
        .overrun         (overrun)
    );

    // Advance one clock and settle past the edge before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic h, input logic [7:0] seed);
        vp = v;
        hp = h;
        r0 = seed;      g0 = seed + 8'd1; b0 = seed + 8'd2;
        r1 = seed + 8'd3; g1 = seed + 8'd4; b1 = seed + 8'd5;
    endtask

    task automatic pulse_reset();
        drive(1'b0, 1'b0, 8'h00);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        vectors++;
        if ({wr_en, wr_addr, wr_data, pair_count, write_done, overrun} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got en=%b addr=%0d data=%h cnt=%0d done=%b ovr=%b, want all 0",
                     wr_en, wr_addr, wr_data, pair_count, write_done, overrun);
        end
        reset = 1'b1;
        tick();
    endtask

    // Four back-to-back pairs starting on the rising-edge cycle.
    task automatic test_full_frame();
        logic [AW-1:0] exp_addr [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                drive(1'b1, 1'b1, 8'h00);
                r0 = 8'h11; g0 = 8'h22; b0 = 8'h33; r1 = 8'h44; g1 = 8'h55; b1 = 8'h66;
            end else begin
                drive(1'b1, 1'b1, 8'(i * 16));
            end
            tick();
            vectors++;
            if (wr_en !== 1'b1 || wr_addr !== exp_addr[i] || pair_count !== 3'(i + 1)
                || write_done !== (i == 3)) begin
                miscompares++;
                $display("FAIL full_frame[%0d]: got en=%b addr=%0d cnt=%0d done=%b, want en=1 addr=%0d cnt=%0d done=%b",
                         i, wr_en, wr_addr, pair_count, write_done, exp_addr[i], i + 1, (i == 3));
            end
            if (i == 0) begin
                vectors++;
                if (wr_data !== 48'h445566112233) begin
                    miscompares++;
                    $display("FAIL packing: got %h want 445566112233", wr_data);
                end
            end
        end
        drive(1'b1, 1'b0, 8'h00);
        tick();
        vectors++;
        if (wr_en !== 1'b0 || write_done !== 1'b1 || pair_count !== 3'd4 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_hold: got en=%b done=%b cnt=%0d ovr=%b, want en=0 done=1 cnt=4 ovr=0",
                     wr_en, write_done, pair_count, overrun);
        end
    endtask

    // New frame from DONE with pairs only in alternate cycles.
    task automatic test_gapped();
        logic [AW-1:0] exp_addr [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
        drive(1'b0, 1'b0, 8'h00);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 8'(8'h80 + i));
            tick();
            vectors++;
            if (wr_en !== 1'b1 || wr_addr !== exp_addr[i] || write_done !== (i == 3)
                || wr_data[47:40] !== 8'(8'h83 + i)) begin
                miscompares++;
                $display("FAIL gapped[%0d]: got en=%b addr=%0d done=%b r1=%h, want en=1 addr=%0d done=%b r1=%h",
                         i, wr_en, wr_addr, write_done, wr_data[47:40], exp_addr[i], (i == 3), 8'(8'h83 + i));
            end
            drive(1'b1, 1'b0, 8'h00);
            tick();
            vectors++;
            if (wr_en !== 1'b0) begin
                miscompares++;
                $display("FAIL gap_cycle[%0d]: got en=%b want 0", i, wr_en);
            end
        end
    endtask

    // Extra pair after DONE is dropped and flags overrun; next frame restarts.
    task automatic test_overrun_after_done();
        drive(1'b1, 1'b1, 8'hA0);
        tick();
        vectors++;
        if (wr_en !== 1'b0 || overrun !== 1'b1 || pair_count !== 3'd4 || write_done !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_done: got en=%b ovr=%b cnt=%0d done=%b, want en=0 ovr=1 cnt=4 done=1",
                     wr_en, overrun, pair_count, write_done);
        end
        drive(1'b0, 1'b0, 8'h00);
        tick();
        drive(1'b1, 1'b1, 8'hB0);
        tick();
        vectors++;
        if (wr_en !== 1'b1 || wr_addr !== 2'd2 || write_done !== 1'b0 || overrun !== 1'b1
            || pair_count !== 3'd1) begin
            miscompares++;
            $display("FAIL new_frame: got en=%b addr=%0d done=%b ovr=%b cnt=%0d, want en=1 addr=2 done=0 ovr=1 cnt=1",
                     wr_en, wr_addr, write_done, overrun, pair_count);
        end
        drive(1'b1, 1'b0, 8'h00);
        tick();
    endtask

    // Reset after two pairs: outputs clear asynchronously, stream restarts cleanly.
    task automatic test_reset_midframe();
        pulse_reset();
        drive(1'b1, 1'b1, 8'h10);
        tick();
        drive(1'b1, 1'b1, 8'h20);
        tick();
        #1;
        reset = 1'b0;
        #1;
        vectors++;
        if ({wr_en, wr_addr, wr_data, pair_count, write_done, overrun} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got en=%b addr=%0d data=%h cnt=%0d done=%b ovr=%b, want all 0",
                     wr_en, wr_addr, wr_data, pair_count, write_done, overrun);
        end
        drive(1'b0, 1'b0, 8'h00);
        tick();
        vectors++;
        if (wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_no_write: got en=%b want 0", wr_en);
        end
        reset = 1'b1;
        drive(1'b0, 1'b1, 8'h30);
        tick();
        vectors++;
        if (wr_en !== 1'b0 || overrun !== 1'b1 || pair_count !== 3'd0) begin
            miscompares++;
            $display("FAIL idle_drop: got en=%b ovr=%b cnt=%0d, want en=0 ovr=1 cnt=0",
                     wr_en, overrun, pair_count);
        end
        drive(1'b1, 1'b1, 8'h40);
        tick();
        vectors++;
        if (wr_en !== 1'b1 || wr_addr !== 2'd2 || pair_count !== 3'd1) begin
            miscompares++;
            $display("FAIL post_reset_frame: got en=%b addr=%0d cnt=%0d, want en=1 addr=2 cnt=1",
                     wr_en, wr_addr, pair_count);
        end
    endtask

    // A new edge mid-frame restarts at (0,0) and flags overrun.
    task automatic test_truncated();
        pulse_reset();
        drive(1'b1, 1'b1, 8'h50);
        tick();
        drive(1'b0, 1'b1, 8'h58);
        tick();
        vectors++;
        if (wr_en !== 1'b1 || wr_addr !== 2'd3 || pair_count !== 3'd2 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL trunc_pre: got en=%b addr=%0d cnt=%0d ovr=%b, want en=1 addr=3 cnt=2 ovr=0",
                     wr_en, wr_addr, pair_count, overrun);
        end
        drive(1'b1, 1'b1, 8'h60);
        tick();
        vectors++;
        if (wr_en !== 1'b1 || wr_addr !== 2'd2 || pair_count !== 3'd1 || overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL trunc_restart: got en=%b addr=%0d cnt=%0d ovr=%b, want en=1 addr=2 cnt=1 ovr=1",
                     wr_en, wr_addr, pair_count, overrun);
        end
        drive(1'b1, 1'b0, 8'h00);
        tick();
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_gapped();
        test_overrun_after_done();
        test_reset_midframe();
        test_truncated();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
